// File: rtl/fas_pkg.sv
// Shared definitions for the FAS FFT datapath.
//   FFT_NPT / FFT_LOGN / FFT_DW : frame size, index width and component width
//   cplx_t                      : packed complex point, {re, im}
//   fill_state_t                : frame packer fill state
//   bitrev4()                   : 4-bit index reversal
package fas_pkg;

    localparam int FFT_NPT  = 16;
    localparam int FFT_LOGN = 4;
    localparam int FFT_DW   = 16;

    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } cplx_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Combinational frame-index to buffer-slot mapping.
//   idx  : arrival index within the frame
//   addr : buffer slot (bit-reversed idx when BITREV=1, idx otherwise)
module fft_bitrev_addr
    import fas_pkg::*;
#(
    parameter int LOGN   = FFT_LOGN,
    parameter bit BITREV = 1'b1
) (
    input  logic [LOGN-1:0] idx,
    output logic [LOGN-1:0] addr
);

    if (BITREV) begin : g_rev
        for (genvar b = 0; b < LOGN; b++) begin : g_bit
            assign addr[b] = idx[LOGN-1-b];
        end
    end else begin : g_pass
        assign addr = idx;
    end

endmodule

// File: rtl/fft_frame_packer.sv
// Collects NPT serial FFT points into a fill buffer, reordering from
// bit-reversed to natural order, then transfers the whole frame into an
// output bank with a one-cycle fft_valid strobe.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid, in_sof      : input point qualifier / first point of frame
//   in_re, in_im          : input point components
//   fft_valid             : one-cycle strobe, new frame on fft_d0..fft_d15
//   fft_d0..fft_d15       : natural-order points {re, im}, held between strobes
//   frame_cnt             : frames emitted, modulo 256
//   sync_err              : one-cycle pulse, frame aborted by a mid-frame in_sof
module fft_frame_packer
    import fas_pkg::*;
#(
    parameter bit BITREV = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_sof,
    input  logic [FFT_DW-1:0]   in_re,
    input  logic [FFT_DW-1:0]   in_im,
    output logic                fft_valid,
    output logic [2*FFT_DW-1:0] fft_d0,
    output logic [2*FFT_DW-1:0] fft_d1,
    output logic [2*FFT_DW-1:0] fft_d2,
    output logic [2*FFT_DW-1:0] fft_d3,
    output logic [2*FFT_DW-1:0] fft_d4,
    output logic [2*FFT_DW-1:0] fft_d5,
    output logic [2*FFT_DW-1:0] fft_d6,
    output logic [2*FFT_DW-1:0] fft_d7,
    output logic [2*FFT_DW-1:0] fft_d8,
    output logic [2*FFT_DW-1:0] fft_d9,
    output logic [2*FFT_DW-1:0] fft_d10,
    output logic [2*FFT_DW-1:0] fft_d11,
    output logic [2*FFT_DW-1:0] fft_d12,
    output logic [2*FFT_DW-1:0] fft_d13,
    output logic [2*FFT_DW-1:0] fft_d14,
    output logic [2*FFT_DW-1:0] fft_d15,
    output logic [7:0]          frame_cnt,
    output logic                sync_err
);

    localparam int NPT  = FFT_NPT;
    localparam int LOGN = FFT_LOGN;
    localparam logic [LOGN-1:0] IDX_ZERO = {LOGN{1'b0}};
    localparam logic [LOGN-1:0] IDX_ONE  = {{(LOGN-1){1'b0}}, 1'b1};
    localparam logic [LOGN-1:0] IDX_LAST = {LOGN{1'b1}};

    fill_state_t     state_r, state_nxt_s;
    logic [LOGN-1:0] idx_r, idx_nxt_s, wr_idx_s, wr_addr_s;
    logic            wr_en_s, emit_s, abort_s;
    cplx_t           wr_data_s;
    cplx_t           fill_r [NPT];
    cplx_t           bank_r [NPT];
    logic            fft_valid_r, sync_err_r;
    logic [7:0]      frame_cnt_r;

    assign wr_data_s = {in_re, in_im};

    fft_bitrev_addr #(
        .LOGN   (LOGN),
        .BITREV (BITREV)
    ) u_addr (
        .idx  (wr_idx_s),
        .addr (wr_addr_s)
    );

    // Fill state machine: next state, write index and frame events
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        wr_idx_s    = idx_r;
        wr_en_s     = 1'b0;
        emit_s      = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_sof) begin
                    wr_en_s     = 1'b1;
                    wr_idx_s    = IDX_ZERO;
                    idx_nxt_s   = IDX_ONE;
                    state_nxt_s = ST_FILL;
                end else begin
                    idx_nxt_s   = IDX_ZERO;
                end
            end
            ST_FILL: begin
                if (in_valid && in_sof) begin
                    // Restart: the new point becomes index 0 of a fresh frame.
                    abort_s   = 1'b1;
                    wr_en_s   = 1'b1;
                    wr_idx_s  = IDX_ZERO;
                    idx_nxt_s = IDX_ONE;
                end else if (in_valid) begin
                    wr_en_s = 1'b1;
                    if (idx_r == IDX_LAST) begin
                        emit_s      = 1'b1;
                        idx_nxt_s   = IDX_ZERO;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = IDX_ZERO;
            end
        endcase
    end

    // State and fill index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Fill buffer: single write port at the reordered slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NPT; k++) begin
                fill_r[k] <= '0;
            end
        end else if (wr_en_s) begin
            fill_r[wr_addr_s] <= wr_data_s;
        end
    end

    // Output bank: whole-frame transfer, last point bypassed from the input
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NPT; k++) begin
                bank_r[k] <= '0;
            end
        end else if (emit_s) begin
            for (int k = 0; k < NPT; k++) begin
                bank_r[k] <= (wr_addr_s == LOGN'(k)) ? wr_data_s : fill_r[k];
            end
        end
    end

    // Status outputs: strobe, abort pulse and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            fft_valid_r <= 1'b0;
            sync_err_r  <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            fft_valid_r <= emit_s;
            sync_err_r  <= abort_s;
            if (emit_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
        end
    end

    assign fft_valid = fft_valid_r;
    assign sync_err  = sync_err_r;
    assign frame_cnt = frame_cnt_r;
    assign fft_d0    = bank_r[0];
    assign fft_d1    = bank_r[1];
    assign fft_d2    = bank_r[2];
    assign fft_d3    = bank_r[3];
    assign fft_d4    = bank_r[4];
    assign fft_d5    = bank_r[5];
    assign fft_d6    = bank_r[6];
    assign fft_d7    = bank_r[7];
    assign fft_d8    = bank_r[8];
    assign fft_d9    = bank_r[9];
    assign fft_d10   = bank_r[10];
    assign fft_d11   = bank_r[11];
    assign fft_d12   = bank_r[12];
    assign fft_d13   = bank_r[13];
    assign fft_d14   = bank_r[14];
    assign fft_d15   = bank_r[15];

endmodule

// File: tb/tb_fft_frame_packer.sv
// Scoreboard bench for fft_frame_packer: stimulus pushes expected frames and
// abort pulses into queues, a negedge monitor pops and compares.
module tb_fft_frame_packer;

    typedef struct {
        logic [511:0] data;
        logic [7:0]   cnt;
        int           cyc;
    } frame_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [15:0] in_re = 16'd0;
    logic [15:0] in_im = 16'd0;
    logic        fft_valid, sync_err;
    logic [7:0]  frame_cnt;
    logic [31:0] d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10, d11, d12, d13, d14, d15;

    fft_frame_packer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im), .fft_valid(fft_valid),
        .fft_d0(d0), .fft_d1(d1), .fft_d2(d2), .fft_d3(d3),
        .fft_d4(d4), .fft_d5(d5), .fft_d6(d6), .fft_d7(d7),
        .fft_d8(d8), .fft_d9(d9), .fft_d10(d10), .fft_d11(d11),
        .fft_d12(d12), .fft_d13(d13), .fft_d14(d14), .fft_d15(d15),
        .frame_cnt(frame_cnt), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    frame_exp_t   fq[$];
    int           sq[$];
    logic [511:0] held = '0;
    logic [7:0]   held_cnt = 8'd0;
    logic [7:0]   exp_cnt = 8'd0;
    logic [31:0]  nat [16];
    bit           done = 1'b0;
    bit           final_done = 1'b0;

    // Arrival position i carries the natural-order point whose index is i reversed.
    function automatic int rev4(input int i);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) begin
            if (((i >> b) & 1) != 0) r = r | (1 << (3 - b));
        end
        return r;
    endfunction

    function automatic logic [511:0] pack_nat();
        logic [511:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = nat[k];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: every non-reset cycle compares strobes, held data and abort pulses.
    always @(negedge clk) begin
        logic [511:0] act;
        frame_exp_t   e;
        int           sc;
        if (!rst) begin
            act = {d15, d14, d13, d12, d11, d10, d9, d8, d7, d6, d5, d4, d3, d2, d1, d0};
            while (fq.size() > 0 && fq[0].cyc < cyc) begin
                e = fq.pop_front();
                chk("strobe_missing", 512'(cyc), 512'(e.cyc));
            end
            while (sq.size() > 0 && sq[0] < cyc) begin
                sc = sq.pop_front();
                chk("sync_err_missing", 512'(cyc), 512'(sc));
            end
            if (fft_valid) begin
                if (fq.size() == 0) begin
                    chk("unexpected_strobe", 512'(fft_valid), 512'(0));
                end else begin
                    e = fq.pop_front();
                    chk("strobe_cycle", 512'(cyc), 512'(e.cyc));
                    chk("frame_data", act, e.data);
                    chk("frame_cnt", 512'(frame_cnt), 512'(e.cnt));
                    held     = e.data;
                    held_cnt = e.cnt;
                end
            end else begin
                chk("hold_data", act, held);
                chk("hold_cnt", 512'(frame_cnt), 512'(held_cnt));
            end
            if (sync_err) begin
                if (sq.size() == 0) begin
                    chk("unexpected_sync_err", 512'(sync_err), 512'(0));
                end else begin
                    sc = sq.pop_front();
                    chk("sync_err_cycle", 512'(cyc), 512'(sc));
                end
            end
            if (done && !final_done) begin
                chk("frames_outstanding", 512'(fq.size()), 512'(0));
                chk("sync_outstanding", 512'(sq.size()), 512'(0));
                final_done = 1'b1;
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic [31:0] d);
        in_valid = v;
        in_sof   = s;
        {in_re, in_im} = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) drive(1'b0, 1'($urandom), $urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        fq.delete();
        sq.delete();
        held     = '0;
        held_cnt = 8'd0;
        exp_cnt  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // gap_mode 0: back-to-back, 1: valid every 3rd cycle, 2: random gaps.
    task automatic send_frame(input int gap_mode, input bit abort);
        frame_exp_t e;
        for (int i = 0; i < 16; i++) begin
            if (gap_mode == 1) idle(2);
            if (gap_mode == 2 && $urandom_range(3) == 0) idle($urandom_range(1, 2));
            if (i == 0 && abort) sq.push_back(cyc + 1);
            if (i == 15) begin
                exp_cnt = exp_cnt + 8'd1;
                e.data  = pack_nat();
                e.cnt   = exp_cnt;
                e.cyc   = cyc + 1;
                fq.push_back(e);
            end
            drive(1'b1, (i == 0), nat[rev4(i)]);
        end
    endtask

    task automatic ramp_frame(input logic [15:0] base);
        logic [15:0] kv;
        for (int k = 0; k < 16; k++) begin
            kv = 16'(k);
            nat[k] = {base + kv, 16'd0 - kv};
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 16; k++) nat[k] = $urandom;
    endtask

    initial begin
        do_reset();
        idle(2);

        // 1: ramp frame, no gaps
        ramp_frame(16'h0000);
        send_frame(0, 1'b0);
        idle(3);

        // 2: same frame, valid every third cycle
        send_frame(1, 1'b0);
        idle(3);

        // 3: back-to-back frames
        ramp_frame(16'h0100);
        send_frame(0, 1'b0);
        ramp_frame(16'h0200);
        send_frame(0, 1'b0);
        idle(3);

        // 4: abort after 7 points, then a full frame
        for (int i = 0; i < 7; i++) drive(1'b1, (i == 0), $urandom);
        rand_frame();
        send_frame(0, 1'b1);
        idle(3);

        // 5: reset after 10 points, then a full frame
        for (int i = 0; i < 10; i++) drive(1'b1, (i == 0), $urandom);
        do_reset();
        idle(2);
        rand_frame();
        send_frame(2, 1'b0);
        idle(3);

        // 6: valid without sof in IDLE is ignored, then 256 frames wrap the counter
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, $urandom);
        idle(5);
        for (int f = 0; f < 256; f++) begin
            rand_frame();
            send_frame((f % 4 == 3) ? 2 : 0, 1'b0);
        end
        idle(4);

        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
